// File: rtl/out_bus_arbiter.sv
// rtl/out_bus_arbiter.sv - two-requester arbiter driving an external address/data/LE bus
//
// Purpose: grants one of two requesters, samples its operands, and runs a
// SETUP -> [STROBE] -> HOLD bus transaction, pulsing done at the end.
// Configuration macro: RR_ARB_EN (defined = round-robin, undefined = fixed
// priority with requester 0 winning conflicts).
//
// Ports:
//   Clk, Rst          clock, asynchronous active-high reset
//   req[1:0]          bus request per requester (bit 0 core, bit 1 aux)
//   wr[1:0]           1 = write with LE strobe, 0 = address-only cycle
//   addr0/addr1       requester address operands
//   data0/data1       requester write data operands
//   gnt[1:0]          one-hot grant, held for the whole transaction
//   done[1:0]         one-cycle completion pulse to the granted requester
//   DataOut_Bus       external data bus
//   Addres_Data_Bus   external address bus
//   LE                external latch enable (write strobe)
//   busy              high whenever the FSM is not idle

module out_bus_arbiter #(
  parameter int WAIT_CYC = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] req,
  input  logic [1:0] wr,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [7:0] DataOut_Bus,
  output logic [7:0] Addres_Data_Bus,
  output logic       LE,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_V = 4'(WAIT_CYC);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  addr_q;
  logic [7:0]  data_q;
  logic        wr_q;
  logic [1:0]  gnt_q;
  logic [1:0]  done_q;
  logic [7:0]  dout_q;
  logic [7:0]  aout_q;
  logic        le_q;
  logic        busy_q;

  logic [1:0]  win_d;
  logic [7:0]  sel_addr_d;
  logic [7:0]  sel_data_d;
  logic        sel_wr_d;

`ifdef RR_ARB_EN
  // Index of the requester served most recently; resets to 1 so that
  // requester 0 wins the first conflict.
  logic        last_q;
`endif

  // Winner selection: a lone request always wins; only a conflict consults
  // the arbitration policy.
  always_comb begin
    win_d = req;
    if (req == 2'b11) begin
`ifdef RR_ARB_EN
      win_d = last_q ? 2'b01 : 2'b10;
`else
      win_d = 2'b01;
`endif
    end
    sel_addr_d = win_d[1] ? addr1 : addr0;
    sel_data_d = win_d[1] ? data1 : data0;
    sel_wr_d   = win_d[1] ? wr[1] : wr[0];
  end

  // Outputs are loaded alongside each state transition, so they always
  // reflect the state being entered.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 8'd0;
      data_q  <= 8'd0;
      wr_q    <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      dout_q  <= 8'd0;
      aout_q  <= 8'd0;
      le_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RR_ARB_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            state_q <= S_SETUP;
            gnt_q   <= win_d;
            addr_q  <= sel_addr_d;
            data_q  <= sel_data_d;
            wr_q    <= sel_wr_d;
            aout_q  <= sel_addr_d;
            dout_q  <= 8'd0;
            le_q    <= 1'b0;
            busy_q  <= 1'b1;
`ifdef RR_ARB_EN
            last_q  <= win_d[1];
`endif
          end
        end
        S_SETUP: begin
          if (wr_q) begin
            state_q <= S_STROBE;
            cnt_q   <= WAIT_V;
            dout_q  <= data_q;
            le_q    <= 1'b1;
          end else begin
            // Address-only: data bus stays 0 through HOLD.
            state_q <= S_HOLD;
            done_q  <= gnt_q;
          end
        end
        S_STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_HOLD;
            le_q    <= 1'b0;
            done_q  <= gnt_q;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        S_HOLD: begin
          state_q <= S_IDLE;
          gnt_q   <= 2'b00;
          done_q  <= 2'b00;
          aout_q  <= 8'd0;
          dout_q  <= 8'd0;
          le_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt             = gnt_q;
  assign done            = done_q;
  assign DataOut_Bus     = dout_q;
  assign Addres_Data_Bus = aout_q;
  assign LE              = le_q;
  assign busy            = busy_q;

endmodule
